// File: rtl/datamem_port_arbiter_if.sv
// Bundle of CPU, host debug/loader and datamem signals around the data memory arbiter.
// slave = arbiter side, master = environment (CPU datapath, host port, datamem).
interface datamem_port_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              cpu_run;
  logic              cpu_wr_en;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_rd_en;
  logic [ADDR_W-1:0] cpu_rd_addr;
  logic              cpu_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_run;
  logic              mem_c17;
  logic [ADDR_W-1:0] mem_write_select;
  logic [DATA_W-1:0] mem_inp;
  logic [ADDR_W-1:0] mem_read_select;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_run, cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_rd_en, cpu_rd_addr,
    output cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_run, mem_c17, mem_write_select, mem_inp, mem_read_select,
    input  mem_rdata
  );

  modport master (
    output cpu_run, cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_rd_en, cpu_rd_addr,
    input  cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_run, mem_c17, mem_write_select, mem_inp, mem_read_select,
    output mem_rdata
  );
endinterface

// File: rtl/datamem_port_arbiter.sv
// Shares the data memory between the CPU datapath (priority) and a 4-phase host port.
// Host accesses borrow an idle memory port; after MAX_WAIT busy cycles the CPU is stalled once.
module datamem_port_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  datamem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    FORCE = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] host_rdata_q;

  logic              cpu_wr;
  logic              cpu_rd;
  logic              port_free;
  logic              slot;

  logic              run_mux;
  logic              c17_mux;
  logic [ADDR_W-1:0] wr_sel_mux;
  logic [DATA_W-1:0] wr_data_mux;
  logic [ADDR_W-1:0] rd_sel_mux;

  assign cpu_wr    = bus.cpu_run & bus.cpu_wr_en;
  assign cpu_rd    = bus.cpu_run & bus.cpu_rd_en;
  assign port_free = bus.host_we ? ~cpu_wr : ~cpu_rd;

  // FORCE owns the port regardless of host_req; ARB only while the request is still up.
  assign slot = (state_q == FORCE) ||
                ((state_q == ARB) && bus.host_req && port_free);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.host_req) begin
          state_d    = ARB;
          wait_cnt_d = '0;
        end
      end
      ARB: begin
        if (!bus.host_req) begin
          state_d = IDLE;
        end else if (port_free) begin
          state_d = ACK;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = FORCE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      FORCE: state_d = ACK;
      ACK: begin
        if (!bus.host_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The port the host does not need always stays with the CPU.
  always_comb begin
    run_mux     = bus.cpu_run;
    c17_mux     = bus.cpu_wr_en;
    wr_sel_mux  = bus.cpu_wr_addr;
    wr_data_mux = bus.cpu_wr_data;
    rd_sel_mux  = bus.cpu_rd_addr;
    if (slot) begin
      if (bus.host_we) begin
        run_mux     = 1'b1;
        c17_mux     = 1'b1;
        wr_sel_mux  = bus.host_addr;
        wr_data_mux = bus.host_wdata;
      end else begin
        rd_sel_mux  = bus.host_addr;
      end
    end
  end

  assign bus.cpu_stall        = (state_q == FORCE);
  assign bus.host_ack         = (state_q == ACK);
  assign bus.host_rdata       = host_rdata_q;
  assign bus.mem_run          = run_mux;
  assign bus.mem_c17          = c17_mux;
  assign bus.mem_write_select = wr_sel_mux;
  assign bus.mem_inp          = wr_data_mux;
  assign bus.mem_read_select  = rd_sel_mux;

  // Combinational memory read is sampled in the slot cycle, so a same-cycle CPU write is not seen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      host_rdata_q <= '0;
    end else if (slot && !bus.host_we) begin
      host_rdata_q <= bus.mem_rdata;
    end
  end

endmodule
